// File: rtl/icache_miss_ctrl_pkg.sv
// Shared types and width helpers for the icache miss controller.
// Imported by the controller top and by its miss counter.
package rvga_types;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    LOAD
  } icache_state_t;

  localparam int NUM_SETS_DEF = 4;
  localparam int LINES_DEF    = 16;
  localparam int ADDR_W_DEF   = 32;
  localparam int LINE_B_DEF   = 32;

  function automatic int field_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_miss_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low reset.
// Holds at all-ones once reached.
module sat_counter
  import rvga_types::*;
#(
  parameter int width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [width-1:0] count_o
);

  logic [width-1:0] count_q;
  logic [width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/icache_miss_ctrl.sv
// Icache miss controller: hit detect, victim latch, line fill from
// pmem and MRU update toward the NMRU replacement stage.
module icache_miss_ctrl
  import rvga_types::*;
#(
  parameter int num_sets      = NUM_SETS_DEF,
  parameter int lines_per_set = LINES_DEF,
  parameter int addr_width    = ADDR_W_DEF,
  parameter int line_bytes    = LINE_B_DEF,
  localparam int IW = field_w(lines_per_set),
  localparam int OW = field_w(line_bytes)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_read,
  input  logic [addr_width-1:0] cpu_addr,
  output logic                  cpu_resp,
  input  logic [num_sets-1:0]   hit_vector,
  input  logic [num_sets-1:0]   icache_replacement_select,
  output logic                  icache_replacement_update,
  output logic [num_sets-1:0]   mru_vector,
  output logic [IW-1:0]         index,
  output logic [num_sets-1:0]   way_load,
  output logic                  pmem_read,
  output logic [addr_width-1:0] pmem_address,
  input  logic                  pmem_resp,
  output logic [15:0]           miss_count
);

  icache_state_t       state_q;
  logic [num_sets-1:0] victim_q;
  logic                req_hit;
  logic                req_miss;

  assign req_hit  = rst && (state_q == IDLE) && cpu_read && (|hit_vector);
  assign req_miss = rst && (state_q == IDLE) && cpu_read && !(|hit_vector);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_miss) begin
            victim_q <= icache_replacement_select;
            state_q  <= FILL;
          end
        end
        FILL: if (pmem_resp) state_q <= LOAD;
        LOAD: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Hit response is same-cycle, so outputs decode from state and
  // inputs; everything is forced low while reset is asserted.
  always_comb begin
    cpu_resp                  = 1'b0;
    icache_replacement_update = 1'b0;
    mru_vector                = '0;
    way_load                  = '0;
    pmem_read                 = 1'b0;
    pmem_address              = '0;
    unique case (1'b1)
      req_hit: begin
        cpu_resp                  = 1'b1;
        icache_replacement_update = 1'b1;
        mru_vector                = hit_vector;
      end
      (rst && state_q == FILL): begin
        pmem_read    = 1'b1;
        pmem_address = {cpu_addr[addr_width-1:OW], {OW{1'b0}}};
      end
      (rst && state_q == LOAD): begin
        way_load                  = victim_q;
        icache_replacement_update = 1'b1;
        mru_vector                = victim_q;
      end
      default: ;
    endcase
  end

  assign index = cpu_addr[OW+IW-1:OW];

  sat_counter #(
    .width(16)
  ) u_miss_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (req_miss),
    .count_o(miss_count)
  );

  a_hit_onehot: assert property (
    @(posedge clk) disable iff (!rst)
    (state_q == IDLE && cpu_read) |-> $onehot0(hit_vector)
  );

endmodule
